// File: rtl/dmux_pkg.sv
// dmux_pkg: shared definitions for the dmux_scan channel scanner.
//   state_t         scanner FSM states (IDLE, RUN)
//   NCH, SEL_W      channel count and select width of the 1-to-8 demux
//   FIRST_CH_UP/DN  channel a sweep begins on (ascending / descending)
//   LAST_CH_UP/DN   channel a sweep ends on   (ascending / descending)
//   first_ch, last_ch, next_ch  helpers that pick by scan direction
package dmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] FIRST_CH_UP = 3'd0;
    localparam logic [SEL_W-1:0] LAST_CH_UP  = 3'd7;
    localparam logic [SEL_W-1:0] FIRST_CH_DN = 3'd7;
    localparam logic [SEL_W-1:0] LAST_CH_DN  = 3'd0;

    function automatic logic [SEL_W-1:0] first_ch(input logic down);
        return down ? FIRST_CH_DN : FIRST_CH_UP;
    endfunction

    function automatic logic [SEL_W-1:0] last_ch(input logic down);
        return down ? LAST_CH_DN : LAST_CH_UP;
    endfunction

    // Modulo-8 step; only used away from the last channel, so wrap is never
    // relied on here (wrap is handled explicitly by the FSM).
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] cur,
                                                 input logic down);
        return down ? cur - 3'd1 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/dmux_dwell_cnt.sv
// dmux_dwell_cnt: loadable down-counter timing how long a channel is held.
//   clk       clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val this cycle (has priority over counting)
//   load_val  value to load (dwell length minus one)
//   en        allow decrementing; the count saturates at zero
//   zero      high while the count is zero (last cycle of the channel)
module dmux_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmux_scan.sv
// dmux_scan: channel scanner feeding a 1-to-8 demultiplexer. Steps sel through
// all eight channels, holding each for a programmable dwell, once (one-shot)
// or continuously, and gates the data bit with busy.
// Optional build macro: DMUX_SCAN_DIR_EN adds a 'dir' input (1 = descending).
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a sweep (honoured only in IDLE, loses to stop)
//   stop       abort a sweep, back to IDLE without done
//   mode       0 = one-shot, 1 = continuous; latched at start
//   dwell      cycles per channel, 0 treated as 1; latched at start
//   dir        (DMUX_SCAN_DIR_EN only) scan direction, latched at start
//   a_in       data bit to distribute
//   a          a_in & busy (combinational)
//   sel        registered channel select
//   busy       high while sweeping
//   ch_strobe  one-cycle pulse in the first cycle of each channel
//   done       one-cycle pulse when a one-shot sweep completes
module dmux_scan
    import dmux_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DMUX_SCAN_DIR_EN
    input  logic               dir,
`endif
    input  logic               a_in,
    output logic               a,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               ch_strobe,
    output logic               done
);

    state_t             state, state_next;
    logic [SEL_W-1:0]   sel_next;
    logic               mode_q, mode_next;
    logic [DWELL_W-1:0] dlen_q, dlen_next;
    logic               strobe_next, done_next;
    logic               cnt_load, cnt_zero;
    logic [DWELL_W-1:0] cnt_val;
    logic               launch;
    logic               down_start, down_run;

    assign launch = (state == IDLE) && start && !stop;

`ifdef DMUX_SCAN_DIR_EN
    logic dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (launch) begin
            dir_q <= dir;
        end
    end

    assign down_start = dir;
    assign down_run   = dir_q;
`else
    assign down_start = 1'b0;
    assign down_run   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            mode_q    <= 1'b0;
            dlen_q    <= DWELL_W'(1);
            ch_strobe <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            mode_q    <= mode_next;
            dlen_q    <= dlen_next;
            ch_strobe <= strobe_next;
            done      <= done_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_next  = state;
        sel_next    = sel;
        mode_next   = mode_q;
        dlen_next   = dlen_q;
        strobe_next = 1'b0;
        done_next   = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = dlen_q - DWELL_W'(1);

        unique case (state)
            IDLE: begin
                sel_next = '0;
                if (launch) begin
                    state_next  = RUN;
                    mode_next   = mode;
                    dlen_next   = (dwell == '0) ? DWELL_W'(1) : dwell;
                    cnt_load    = 1'b1;
                    cnt_val     = dlen_next - DWELL_W'(1);
                    sel_next    = first_ch(down_start);
                    strobe_next = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    sel_next   = '0;
                end else if (cnt_zero) begin
                    if (sel != last_ch(down_run)) begin
                        sel_next    = next_ch(sel, down_run);
                        cnt_load    = 1'b1;
                        strobe_next = 1'b1;
                    end else if (mode_q) begin
                        sel_next    = first_ch(down_run);
                        cnt_load    = 1'b1;
                        strobe_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        sel_next   = '0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
            end
        endcase
    end

    dmux_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (state == RUN),
        .zero     (cnt_zero)
    );

    assign busy = (state == RUN);
    assign a    = a_in & busy;

endmodule

// File: tb/tb_dmux_scan.sv
// tb_dmux_scan: directed self-checking bench for dmux_scan.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_dmux_scan;
    import dmux_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [7:0]       dwell;
    logic             dir;
    logic             a_in;
    logic             a;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             ch_strobe;
    logic             done;

    int checks = 0;
    int errors = 0;
    int strobes;

    dmux_scan #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
`ifdef DMUX_SCAN_DIR_EN
        .dir       (dir),
`endif
        .a_in      (a_in),
        .a         (a),
        .sel       (sel),
        .busy      (busy),
        .ch_strobe (ch_strobe),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " sel"}, 32'(sel), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " strobe"}, 32'(ch_strobe), 0);
        check({tag, " done"}, 32'(done), 32'(exp_done));
        check({tag, " a"}, 32'(a), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        dwell = 8'd3; dir = 1'b0; a_in = 1'b1;

        // Reset, then idle.
        step(); step();
        check_idle("reset", 1'b0);
        rst = 1'b0;
        step();
        check_idle("idle", 1'b0);

        // One-shot, dwell 3: 24 busy cycles, sel = i/3, strobe when i%3==0.
        mode = 1'b0; dwell = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        strobes = 0;
        for (int i = 0; i < 24; i++) begin
            check("os sel", 32'(sel), 32'(i / 3));
            check("os busy", 32'(busy), 1);
            check("os strobe", 32'(ch_strobe), 32'((i % 3) == 0));
            check("os done", 32'(done), 0);
            check("os a", 32'(a), 1);
            if (ch_strobe) strobes++;
            dwell = (i == 5) ? 8'd7 : dwell;   // ignored until next start
            mode  = (i == 6) ? 1'b1 : mode;    // ignored until next start
            start = (i == 10);                 // ignored in RUN
            step();
        end
        check("os strobe count", 32'(strobes), 8);
        check_idle("os end", 1'b1);
        step();
        check_idle("os after", 1'b0);

        // Continuous, dwell 0 (acts as 1): sel every cycle, wraps, stop at 4.
        mode = 1'b1; dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("ct sel", 32'(sel), 32'(i % 8));
            check("ct strobe", 32'(ch_strobe), 1);
            check("ct busy", 32'(busy), 1);
            check("ct done", 32'(done), 0);
            step();
        end
        check("ct sel at stop", 32'(sel), 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("ct stopped", 1'b0);
        step();
        check_idle("ct stopped+1", 1'b0);

        // Reset mid-sweep at sel 5.
        mode = 1'b0; dwell = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mr sel before", 32'(sel), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mr reset", 1'b0);
        dwell = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("mr restart sel", 32'(sel), 0);
        check("mr restart busy", 32'(busy), 1);
        check("mr restart strobe", 32'(ch_strobe), 1);
        step();
        check("mr hold sel", 32'(sel), 0);
        check("mr hold strobe", 32'(ch_strobe), 0);
        step();
        check("mr next sel", 32'(sel), 1);
        check("mr next strobe", 32'(ch_strobe), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("mr stop", 1'b0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_idle("start+stop", 1'b0);

        // Back-to-back: start held through done relaunches after the IDLE cycle.
        mode = 1'b0; dwell = 8'd1; start = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            check("bb sel", 32'(sel), 32'(i));
            check("bb busy", 32'(busy), 1);
            step();
        end
        check_idle("bb done", 1'b1);
        step();
        start = 1'b0;
        check("bb relaunch sel", 32'(sel), 0);
        check("bb relaunch busy", 32'(busy), 1);
        check("bb relaunch strobe", 32'(ch_strobe), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("bb stop", 1'b0);

`ifdef DMUX_SCAN_DIR_EN
        // Descending one-shot, dwell 2: sel 7..0, 16 busy cycles.
        mode = 1'b0; dwell = 8'd2; dir = 1'b1; start = 1'b1;
        step();
        start = 1'b0; dir = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("dn sel", 32'(sel), 32'(7 - i / 2));
            check("dn busy", 32'(busy), 1);
            check("dn strobe", 32'(ch_strobe), 32'((i % 2) == 0));
            check("dn done", 32'(done), 0);
            step();
        end
        check_idle("dn end", 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
